// File: rtl/hyperram_user_mem.sv
// hyperram_user_mem: memory-backed stand-in for the HyperRAM controller user request port.
// Requests are captured in IDLE, wait out the selected latency, then write once or stream a read burst.
module hyperram_user_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        mem_or_reg,
  input  logic [3:0]  wr_byte_en,
  input  logic [7:0]  rd_num_dwords,
  input  logic [31:0] addr,
  input  logic [31:0] wr_d,
  input  logic [7:0]  latency_1x,
  input  logic [7:0]  latency_2x,
  output logic [31:0] rd_d,
  output logic        rd_rdy,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LAT, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic [7:0] lat_q, lat_d, beats_q, beats_d, lat_sel;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0] wd_q, wd_d, rd_d_q, rd_d_d, cur, merged;
  logic [3:0] be_q, be_d;
  logic is_reg_q, is_reg_d, is_wr_q, is_wr_d;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  logic [31:0] mem [2**DEPTH_LOG2];
  logic unused_addr;
  assign unused_addr = ^addr[31:DEPTH_LOG2];
  assign lat_sel = mem_or_reg ? latency_1x : latency_2x;
  assign cur = is_reg_q ? regs_q[idx_q[1:0]] : mem[idx_q];
  assign rd_d = rd_d_q;
  assign rd_rdy = state_q == READ;
  assign busy = state_q != IDLE;
  always_comb begin
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be_q[i] ? wd_q[8*i +: 8] : cur[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    beats_d = beats_q;
    idx_d = idx_q;
    wd_d = wd_q;
    be_d = be_q;
    is_reg_d = is_reg_q;
    is_wr_d = is_wr_q;
    rd_d_d = rd_d_q;
    regs_d = regs_q;
    case (state_q)
      IDLE: if (rd_req || wr_req) begin
        state_d = LAT;
        lat_d = (lat_sel == 8'd0) ? 8'd1 : lat_sel;
        beats_d = rd_num_dwords;
        idx_d = addr[DEPTH_LOG2-1:0];
        wd_d = wr_d;
        be_d = wr_byte_en;
        is_reg_d = mem_or_reg;
        is_wr_d = wr_req;
      end
      LAT: if (lat_q != 8'd1) lat_d = lat_q - 8'd1;
        else if (is_wr_q) state_d = WRITE;
        else if (beats_q == 8'd0) state_d = IDLE;
        else begin
          state_d = READ;
          rd_d_d = cur;
          idx_d = idx_q + 1'b1;
          beats_d = beats_q - 8'd1;
        end
      WRITE: begin
        state_d = IDLE;
        if (is_reg_q) regs_d[idx_q[1:0]] = merged;
      end
      default: if (beats_q == 8'd0) state_d = IDLE;
        else begin
          rd_d_d = cur;
          idx_d = idx_q + 1'b1;
          beats_d = beats_q - 8'd1;
        end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q <= '0;
      beats_q <= '0;
      idx_q <= '0;
      wd_q <= '0;
      be_q <= '0;
      is_reg_q <= 1'b0;
      is_wr_q <= 1'b0;
      rd_d_q <= '0;
      regs_q[0] <= 32'h0000_8F1F;
      regs_q[1] <= 32'h0000_0002;
      regs_q[2] <= '0;
      regs_q[3] <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      beats_q <= beats_d;
      idx_q <= idx_d;
      wd_q <= wd_d;
      be_q <= be_d;
      is_reg_q <= is_reg_d;
      is_wr_q <= is_wr_d;
      rd_d_q <= rd_d_d;
      regs_q <= regs_d;
    end
  end
  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == WRITE && !is_reg_q) mem[idx_q] <= merged;
  end
endmodule

// File: tb/tb_hyperram_user_mem.sv
// tb_hyperram_user_mem: directed plus randomized requests checked cycle by cycle against an array model.
module tb_hyperram_user_mem;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset, rd_req, wr_req, mem_or_reg, rd_rdy, busy;
  logic [3:0] wr_byte_en;
  logic [7:0] rd_num_dwords, latency_1x, latency_2x;
  logic [31:0] addr, wr_d, rd_d;
  int checks = 0;
  int failures = 0;
  logic [31:0] mmem [DEPTH];
  logic [31:0] mregs [4];
  logic [31:0] last_rd;

  hyperram_user_mem #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .mem_or_reg(mem_or_reg),
    .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords), .addr(addr), .wr_d(wr_d),
    .latency_1x(latency_1x), .latency_2x(latency_2x), .rd_d(rd_d), .rd_rdy(rd_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mregs[0] = 32'h0000_8F1F;
    mregs[1] = 32'h0000_0002;
    mregs[2] = 32'h0;
    mregs[3] = 32'h0;
    last_rd = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rdy", {31'h0, rd_rdy}, 32'h0);
    chk("rst_rd_d", rd_d, 32'h0);
    reset = 1'b0;
  endtask

  // Issues one request in the current idle cycle and checks busy/rd_rdy/rd_d in every cycle until idle again.
  task automatic req(input bit rd, input bit wr, input bit isreg, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input logic [7:0] n,
                     input logic [7:0] l1, input logic [7:0] l2, input bit poke);
    int lat, kmax;
    lat = isreg ? int'(l1) : int'(l2);
    if (lat == 0) lat = 1;
    rd_req = rd; wr_req = wr; mem_or_reg = isreg; addr = a; wr_d = d;
    wr_byte_en = be; rd_num_dwords = n; latency_1x = l1; latency_2x = l2;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    addr = $urandom; wr_d = $urandom; wr_byte_en = 4'($urandom); rd_num_dwords = 8'($urandom);
    mem_or_reg = 1'($urandom); latency_1x = 8'($urandom); latency_2x = 8'($urandom);
    kmax = wr ? lat + 2 : lat + int'(n) + 1;
    for (int k = 1; k <= kmax; k++) begin
      bit eb, er;
      logic [31:0] ia;
      eb = wr ? (k <= lat + 1) : (k <= lat + int'(n));
      er = !wr && k >= lat + 1 && k <= lat + int'(n);
      if (er) begin
        ia = a + 32'(k - lat - 1);
        last_rd = isreg ? mregs[ia[1:0]] : mmem[ia[DL-1:0]];
      end
      chk($sformatf("busy k=%0d", k), {31'h0, busy}, {31'h0, eb});
      chk($sformatf("rdy k=%0d", k), {31'h0, rd_rdy}, {31'h0, er});
      chk($sformatf("rd_d k=%0d", k), rd_d, last_rd);
      if (poke && k == 2) begin
        wr_req = 1'b1; mem_or_reg = isreg; addr = a; wr_d = ~d; wr_byte_en = 4'hF;
      end else wr_req = 1'b0;
      if (k < kmax) tick();
    end
    wr_req = 1'b0;
    if (wr) begin
      logic [31:0] t;
      t = isreg ? mregs[a[1:0]] : mmem[a[DL-1:0]];
      for (int b = 0; b < 4; b++) if (be[b]) t[8*b +: 8] = d[8*b +: 8];
      if (isreg) mregs[a[1:0]] = t;
      else mmem[a[DL-1:0]] = t;
    end
  endtask

  initial begin
    rd_req = 0; wr_req = 0; mem_or_reg = 0; wr_byte_en = 0; rd_num_dwords = 0;
    addr = 0; wr_d = 0; latency_1x = 0; latency_2x = 0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) req(0, 1, 0, 32'(i), $urandom, 4'hF, 0, 0, 8'($urandom_range(0, 3)), 0);
    req(0, 1, 0, 32'h0, 32'h33, 4'hF, 0, 0, 22, 0);
    req(1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 22, 0);
    chk("wr_rd_33", rd_d, 32'h33);
    req(0, 1, 0, 32'h5, 32'hAABBCCDD, 4'hF, 0, 0, 2, 0);
    req(0, 1, 0, 32'h5, 32'h11223344, 4'b0101, 0, 0, 2, 0);
    req(1, 0, 0, 32'h5, 32'h0, 4'h0, 1, 0, 2, 0);
    chk("be_merge", rd_d, 32'hAA22CC44);
    req(0, 1, 0, 32'd14, 32'd1, 4'hF, 0, 0, 1, 0);
    req(0, 1, 0, 32'd15, 32'd2, 4'hF, 0, 0, 1, 0);
    req(0, 1, 0, 32'd0, 32'd3, 4'hF, 0, 0, 1, 0);
    req(0, 1, 0, 32'd1, 32'd4, 4'hF, 0, 0, 1, 0);
    req(1, 0, 0, 32'd14, 32'h0, 4'h0, 4, 0, 3, 0);
    chk("wrap_last", rd_d, 32'd4);
    do_reset();
    req(1, 0, 1, 32'h0, 32'h0, 4'h0, 2, 0, 5, 0);
    chk("reg1_val", rd_d, 32'h2);
    req(1, 1, 0, 32'd7, 32'hDEADBEEF, 4'hF, 3, 0, 2, 0);
    req(1, 0, 0, 32'd7, 32'h0, 4'h0, 1, 0, 0, 0);
    chk("collide_wr", rd_d, 32'hDEADBEEF);
    req(0, 1, 0, 32'd9, 32'h0BADF00D, 4'hF, 0, 0, 3, 1);
    req(1, 0, 0, 32'd9, 32'h0, 4'h0, 1, 0, 3, 0);
    chk("ignore_busy", rd_d, 32'h0BADF00D);
    rd_req = 1; mem_or_reg = 0; addr = 32'd3; rd_num_dwords = 4; latency_2x = 2;
    tick();
    rd_req = 0;
    repeat (3) tick();
    chk("mid_rdy", {31'h0, rd_rdy}, 32'h1);
    chk("mid_beat2", rd_d, mmem[4]);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_rdy", {31'h0, rd_rdy}, 32'h0);
    chk("arst_rd_d", rd_d, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_rdy", {31'h0, rd_rdy}, 32'h0);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);
      tick();
    end
    req(1, 0, 0, 32'd3, 32'h0, 4'h0, 4, 0, 1, 0);
    for (int t = 0; t < 40; t++) begin
      bit w, r, g;
      w = 1'($urandom);
      r = !w || 1'($urandom);
      g = ($urandom_range(0, 3) == 0);
      req(r, w, g, $urandom, $urandom, 4'($urandom), 8'($urandom_range(0, 5)),
          8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
